// File: rtl/vector_store_serializer.sv
// Serializes one LANES*LANE_W vector store into consecutive LANE_W word writes on a scalar memory port.
// Optional build macro VSTORE_LANE_MASK_EN adds a per-lane write mask (in_mask).
module vector_store_serializer #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [ADDR_W-1:0]         in_addr,
`ifdef VSTORE_LANE_MASK_EN
  input  logic [LANES-1:0]          in_mask,
`endif
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LANE_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic [LANES*LANE_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      done_q, done_d;

  logic [LW-1:0]             first_lane;
  logic [LW-1:0]             next_lane;
  logic                      has_next;
  logic                      accept_write;
  logic [LANE_W-1:0]         lane_word [LANES];

`ifdef VSTORE_LANE_MASK_EN
  logic [LANES-1:0]          mask_q, mask_d;

  // Masked lanes cost no cycles: jump straight to the lowest set bit (above the current lane).
  always_comb begin
    first_lane = '0;
    next_lane  = lane_q;
    has_next   = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (in_mask[i]) begin
        first_lane = LW'(i);
      end
      if (mask_q[i] && (LW'(i) > lane_q)) begin
        next_lane = LW'(i);
        has_next  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    first_lane = '0;
    next_lane  = lane_q + LW'(1);
    has_next   = (lane_q != LW'(LANES - 1));
  end
`endif

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_word[i] = data_q[i*LANE_W +: LANE_W];
    end
  end

  assign accept_write = (state_q == WRITE) && mem_ready;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
`ifdef VSTORE_LANE_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          addr_d = in_addr;
          lane_d = first_lane;
`ifdef VSTORE_LANE_MASK_EN
          mask_d = in_mask;
          // An all-zero mask completes immediately without ever entering WRITE.
          if (in_mask == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = WRITE;
          end
`else
          state_d = WRITE;
`endif
        end
      end
      WRITE: begin
        if (accept_write) begin
          if (has_next) begin
            lane_d = next_lane;
          end else begin
            state_d = IDLE;
            lane_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
`ifdef VSTORE_LANE_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
`ifdef VSTORE_LANE_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Port values come only from held state, so they stay put across mem_ready stalls.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == WRITE);
    mem_we    = (state_q == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WRITE) begin
      mem_addr  = addr_q + (ADDR_W'(lane_q) * ADDR_W'(STEP));
      mem_wdata = lane_word[lane_q];
    end
    done = done_q;
  end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed self-checking bench for vector_store_serializer; mask scenarios build only with VSTORE_LANE_MASK_EN.
module tb_vector_store_serializer;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [31:0]  in_addr;
  logic [3:0]   in_mask;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] VEC_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] VEC_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] VEC_C = 128'h99999999_88888888_77777777_66666666;

  logic [31:0] words_a [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] words_b [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};

  vector_store_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
`ifdef VSTORE_LANE_MASK_EN
    .in_mask   (in_mask),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
    in_data = '0; in_addr = '0; in_mask = 4'hF;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({in_ready, mem_we, done} !== 3'b100) begin n_err++; $display("[TB] FAIL idle_after_reset got %b want 100", {in_ready, mem_we, done}); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    in_data = VEC_A; in_addr = 32'h100; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_we, busy, in_ready, done, mem_addr, mem_wdata} !== {4'b1100, exp_addr[i], words_a[i]}) begin
        n_err++;
        $display("[TB] FAIL basic_lane%0d got we=%b busy=%b rdy=%b done=%b addr=%h data=%h want we=1 busy=1 rdy=0 done=0 addr=%h data=%h",
                 i, mem_we, busy, in_ready, done, mem_addr, mem_wdata, exp_addr[i], words_a[i]);
      end
      tick();
    end
    n_cmp++; if ({done, in_ready, mem_we, busy} !== 4'b1100) begin n_err++; $display("[TB] FAIL basic_done_cycle got done/rdy/we/busy=%b want 1100", {done, in_ready, mem_we, busy}); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL basic_done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_stall();
    in_data = VEC_A; in_addr = 32'h100; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'h11111111}) begin n_err++; $display("[TB] FAIL stall_lane0 got addr=%h data=%h want 100/11111111", mem_addr, mem_wdata); end
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b0;
      n_cmp++;
      if ({mem_we, done, mem_addr, mem_wdata} !== {2'b10, 32'h104, 32'h22222222}) begin
        n_err++;
        $display("[TB] FAIL stall_hold%0d got we=%b done=%b addr=%h data=%h want we=1 done=0 104/22222222", k, mem_we, done, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_ready = 1'b1;
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h104, 32'h22222222}) begin n_err++; $display("[TB] FAIL stall_release got addr=%h data=%h want 104/22222222", mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h108, 32'h33333333}) begin n_err++; $display("[TB] FAIL stall_lane2 got addr=%h data=%h want 108/33333333", mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h10C, 32'h44444444}) begin n_err++; $display("[TB] FAIL stall_lane3 got addr=%h data=%h want 10C/44444444", mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({done, in_ready, mem_we} !== 3'b110) begin n_err++; $display("[TB] FAIL stall_done got done/rdy/we=%b want 110", {done, in_ready, mem_we}); end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    in_data = VEC_A; in_addr = 32'hFFFF_FFF8; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_addr[i], words_a[i]}) begin
        n_err++;
        $display("[TB] FAIL wrap_lane%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i, mem_we, mem_addr, mem_wdata, exp_addr[i], words_a[i]);
      end
      tick();
    end
    n_cmp++; if ({done, in_ready} !== 2'b11) begin n_err++; $display("[TB] FAIL wrap_done got done/rdy=%b want 11", {done, in_ready}); end
    tick();
  endtask

  task automatic test_reset_mid();
    in_data = VEC_A; in_addr = 32'h100; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if ({mem_we, mem_addr} !== {1'b1, 32'h104}) begin n_err++; $display("[TB] FAIL midreset_lane1 got we=%b addr=%h want 1/104", mem_we, mem_addr); end
    tick();
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    n_cmp++; if ({mem_we, in_ready, busy, done} !== 4'b0100) begin n_err++; $display("[TB] FAIL midreset_abort got we/rdy/busy/done=%b want 0100", {mem_we, in_ready, busy, done}); end
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({mem_we, done, in_ready} !== 3'b001) begin
        n_err++;
        $display("[TB] FAIL midreset_quiet%0d got we/done/rdy=%b want 001 (addr=%h)", k, {mem_we, done, in_ready}, mem_addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    in_data = VEC_A; in_addr = 32'h100; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_data = VEC_B; in_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_we, in_ready, mem_addr, mem_wdata} !== {2'b10, 32'h100 + 32'(4 * i), words_a[i]}) begin
        n_err++;
        $display("[TB] FAIL b2b_first_lane%0d got we=%b rdy=%b addr=%h data=%h want we=1 rdy=0 addr=%h data=%h",
                 i, mem_we, in_ready, mem_addr, mem_wdata, 32'h100 + 32'(4 * i), words_a[i]);
      end
      tick();
    end
    n_cmp++; if ({done, in_ready} !== 2'b11) begin n_err++; $display("[TB] FAIL b2b_done_and_ready got done/rdy=%b want 11", {done, in_ready}); end
    tick();
    in_valid = 1'b0;
    in_data = VEC_C; in_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_we, done, mem_addr, mem_wdata} !== {2'b10, 32'h200 + 32'(4 * i), words_b[i]}) begin
        n_err++;
        $display("[TB] FAIL b2b_second_lane%0d got we=%b done=%b addr=%h data=%h want we=1 done=0 addr=%h data=%h",
                 i, mem_we, done, mem_addr, mem_wdata, 32'h200 + 32'(4 * i), words_b[i]);
      end
      tick();
    end
    waited = 0;
    while (done !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_cmp++; if (waited != 0) begin n_err++; $display("[TB] FAIL b2b_second_done got %0d extra cycles want 0", waited); end
    tick();
    n_cmp++; if ({in_ready, mem_we, done} !== 3'b100) begin n_err++; $display("[TB] FAIL b2b_idle got rdy/we/done=%b want 100", {in_ready, mem_we, done}); end
  endtask

`ifdef VSTORE_LANE_MASK_EN
  task automatic test_mask();
    in_data = VEC_A; in_addr = 32'h100; in_mask = 4'b1010; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h104, 32'h22222222}) begin n_err++; $display("[TB] FAIL mask_lane1 got we=%b addr=%h data=%h want 1/104/22222222", mem_we, mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h10C, 32'h44444444}) begin n_err++; $display("[TB] FAIL mask_lane3 got we=%b addr=%h data=%h want 1/10C/44444444", mem_we, mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({done, in_ready, mem_we} !== 3'b110) begin n_err++; $display("[TB] FAIL mask_done got done/rdy/we=%b want 110", {done, in_ready, mem_we}); end
    tick();
    in_mask = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_mask = 4'hF;
    n_cmp++; if ({done, mem_we, in_ready, busy} !== 4'b1010) begin n_err++; $display("[TB] FAIL mask_zero got done/we/rdy/busy=%b want 1010", {done, mem_we, in_ready, busy}); end
    tick();
    n_cmp++; if ({done, mem_we} !== 2'b00) begin n_err++; $display("[TB] FAIL mask_zero_after got done/we=%b want 00", {done, mem_we}); end
  endtask
`endif

  initial begin
    $display("[TB] vector_store_serializer directed test start");
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
`ifdef VSTORE_LANE_MASK_EN
    test_mask();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
